// File: rtl/eth_tx_mii.sv
// MII (4-bit) Ethernet transmitter: pops payload bytes from the TX FIFO and sends
// preamble, SFD, payload, zero pad, CRC-32 FCS and the inter-frame gap.
module eth_tx_mii #(
    parameter int LEN_W       = 11,
    parameter int MIN_LEN     = 60,
    parameter int PRE_BYTES   = 7,
    parameter int IFG_NIBBLES = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd,
    input  logic [7:0]       i_fifo_data,
    output logic [3:0]       o_mii_txd,
    output logic             o_mii_txen,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_underrun
);

    localparam int TW = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [TW-1:0]    tick;
    logic             nib;
    logic [7:0]       byte_q;
    logic [31:0]      crc;
    logic             pop_slot;

    logic [LEN_W:0]   cnt_x;
    logic [LEN_W:0]   len_x;
    logic             more_data;
    logic             more_pad;
    logic             next_more;

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ({1'b0, r[31:1]} ^ 32'hEDB88320) : {1'b0, r[31:1]};
        return r;
    endfunction

    // cnt holds the number of bytes already loaded into byte_q
    always_comb begin
        cnt_x     = {1'b0, cnt};
        len_x     = {1'b0, len_q};
        more_data = cnt_x < len_x;
        more_pad  = cnt_x < (LEN_W+1)'(MIN_LEN);
        next_more = (cnt_x + (LEN_W+1)'(1)) < len_x;
    end

    // A pop is only issued when the FIFO has data; an empty FIFO in a pop slot aborts.
    assign o_fifo_rd = pop_slot & ~i_fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            tick       <= '0;
            nib        <= 1'b0;
            byte_q     <= '0;
            crc        <= '1;
            pop_slot   <= 1'b0;
            o_mii_txd  <= '0;
            o_mii_txen <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
            if (pop_slot && i_fifo_empty) begin
                state      <= IFG;
                tick       <= '0;
                pop_slot   <= 1'b0;
                o_mii_txd  <= '0;
                o_mii_txen <= 1'b0;
                o_underrun <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            state      <= PRE;
                            len_q      <= i_len;
                            cnt        <= '0;
                            tick       <= '0;
                            nib        <= 1'b0;
                            crc        <= '1;
                            pop_slot   <= 1'b0;
                            o_mii_txd  <= 4'h5;
                            o_mii_txen <= 1'b1;
                            o_busy     <= 1'b1;
                        end
                    end
                    PRE: begin
                        o_mii_txd <= 4'h5;
                        if (tick == TW'(2*PRE_BYTES-1)) begin
                            state    <= SFD;
                            nib      <= 1'b0;
                            pop_slot <= (len_q != '0);
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    SFD, DATA, PAD: begin
                        if (!nib) begin
                            o_mii_txd <= (state == SFD) ? 4'hD : byte_q[7:4];
                            nib       <= 1'b1;
                            pop_slot  <= 1'b0;
                        end else begin
                            nib <= 1'b0;
                            if (more_data) begin
                                state     <= DATA;
                                byte_q    <= i_fifo_data;
                                o_mii_txd <= i_fifo_data[3:0];
                                crc       <= crc8(crc, i_fifo_data);
                                cnt       <= cnt + LEN_W'(1);
                                pop_slot  <= next_more;
                            end else if (more_pad) begin
                                state     <= PAD;
                                byte_q    <= '0;
                                o_mii_txd <= '0;
                                crc       <= crc8(crc, 8'h00);
                                cnt       <= cnt + LEN_W'(1);
                            end else begin
                                state     <= FCS;
                                tick      <= '0;
                                o_mii_txd <= ~crc[3:0];
                                crc       <= {4'h0, crc[31:4]};
                            end
                        end
                    end
                    FCS: begin
                        if (tick == TW'(7)) begin
                            state      <= IFG;
                            tick       <= '0;
                            o_mii_txd  <= '0;
                            o_mii_txen <= 1'b0;
                            o_done     <= 1'b1;
                        end else begin
                            tick      <= tick + TW'(1);
                            o_mii_txd <= ~crc[3:0];
                            crc       <= {4'h0, crc[31:4]};
                        end
                    end
                    IFG: begin
                        if (tick == TW'(IFG_NIBBLES-1)) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_mii.sv
// Directed self-checking bench for eth_tx_mii: FIFO model, nibble capture and a CRC-32 model.
module tb_eth_tx_mii;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [10:0] i_len;
    logic        i_fifo_empty;
    logic        o_fifo_rd;
    logic [7:0]  i_fifo_data;
    logic [3:0]  o_mii_txd;
    logic        o_mii_txen;
    logic        o_busy;
    logic        o_done;
    logic        o_underrun;

    eth_tx_mii #(.LEN_W(11), .MIN_LEN(60), .PRE_BYTES(7), .IFG_NIBBLES(24)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
        .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd), .i_fifo_data(i_fifo_data),
        .o_mii_txd(o_mii_txd), .o_mii_txen(o_mii_txen), .o_busy(o_busy),
        .o_done(o_done), .o_underrun(o_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pop seen at negedge, applied at the next posedge
    logic [7:0] mem [0:2047];
    int         rd_idx;
    int         fifo_avail;
    logic       fifo_clr;
    logic       rd_q;

    assign i_fifo_empty = (rd_idx >= fifo_avail);

    always @(negedge clk) rd_q <= o_fifo_rd;
    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_idx <= 0;
        end else if (rd_q) begin
            i_fifo_data <= mem[rd_idx];
            rd_idx      <= rd_idx + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    logic [3:0] cap   [0:8191];
    logic [3:0] exp_s [0:8191];
    int cap_n, exp_n;
    int rd_cnt, done_cnt, unr_cnt, done_at, unr_at;
    int first_txen, last_txen, first_rd_at, busy_fall, txd_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic build_exp(input int len);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        int          total;
        c     = 32'hFFFFFFFF;
        exp_n = 0;
        for (int i = 0; i < 15; i++) begin exp_s[exp_n] = 4'h5; exp_n++; end
        exp_s[exp_n] = 4'hD; exp_n++;
        total = (len > 60) ? len : 60;
        for (int i = 0; i < total; i++) begin
            b = (i < len) ? mem[i] : 8'h00;
            c = crc_byte(c, b);
            exp_s[exp_n] = b[3:0]; exp_n++;
            exp_s[exp_n] = b[7:4]; exp_n++;
        end
        fcs = ~c;
        for (int k = 0; k < 8; k++) begin exp_s[exp_n] = fcs[4*k +: 4]; exp_n++; end
    endtask

    function automatic int stream_errors(input int n);
        int e = 0;
        for (int i = 0; i < n; i++) if (cap[i] !== exp_s[i]) e++;
        return e;
    endfunction

    task automatic kick(input int len, input int avail);
        @(negedge clk);
        fifo_clr   = 1'b1;
        fifo_avail = avail;
        @(negedge clk);
        fifo_clr = 1'b0;
        i_len    = 11'(len);
        i_start  = 1'b1;
    endtask

    // Cycle 0 is the first cycle after the start was sampled; runs until busy falls
    task automatic capture(input int max_cycles, input bit hold);
        bit seen_busy = 1'b0;
        cap_n = 0; rd_cnt = 0; done_cnt = 0; unr_cnt = 0; txd_bad = 0;
        done_at = -1; unr_at = -1; first_txen = -1; last_txen = -1;
        first_rd_at = -1; busy_fall = -1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) i_start = 1'b0;
            if (o_mii_txen === 1'b1) begin
                cap[cap_n] = o_mii_txd;
                cap_n++;
                if (first_txen < 0) first_txen = c;
                last_txen = c;
            end else if (o_mii_txd !== 4'h0) begin
                txd_bad++;
            end
            if (o_fifo_rd === 1'b1) begin
                if (first_rd_at < 0) first_rd_at = c;
                rd_cnt++;
            end
            if (o_done === 1'b1) begin done_cnt++; done_at = c; end
            if (o_underrun === 1'b1) begin unr_cnt++; unr_at = c; end
            if (o_busy === 1'b1) seen_busy = 1'b1;
            else if (seen_busy) begin busy_fall = c; break; end
        end
        checks++;
        if (busy_fall < 0) begin
            errors++;
            $display("FAIL capture_timeout: busy never fell within %0d cycles (txen cycles=%0d)", max_cycles, cap_n);
        end
    endtask

    task automatic test_crc_model();
        logic [31:0] c;
        logic [7:0]  s [0:8];
        for (int i = 0; i < 9; i++) s[i] = 8'h31 + 8'(i);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_byte(c, s[i]);
        checks++;
        if (~c !== 32'hCBF43926) begin
            errors++; $display("FAIL crc_model: got %h want cbf43926", ~c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_mii_txen, o_mii_txd, o_busy, o_done, o_underrun, o_fifo_rd} !== 9'h0) begin
            errors++;
            $display("FAIL reset_outputs: txen=%b txd=%h busy=%b done=%b unr=%b rd=%b want all 0",
                     o_mii_txen, o_mii_txd, o_busy, o_done, o_underrun, o_fifo_rd);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_mii_txen, o_busy} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: txen=%b busy=%b want 0 0", o_mii_txen, o_busy);
        end
    endtask

    task automatic test_len64();
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        build_exp(64);
        kick(64, 64);
        capture(400, 1'b0);
        checks++;
        if (first_txen !== 0) begin errors++; $display("FAIL l64_first_txen: cycle %0d want 0", first_txen); end
        checks++;
        if (cap_n !== 152 || last_txen - first_txen + 1 !== cap_n) begin
            errors++; $display("FAIL l64_txen_len: %0d (span %0d) want 152", cap_n, last_txen - first_txen + 1);
        end
        checks++;
        if (rd_cnt !== 64) begin errors++; $display("FAIL l64_pops: %0d want 64", rd_cnt); end
        checks++;
        if (first_rd_at !== 14) begin errors++; $display("FAIL l64_first_pop: cycle %0d want 14", first_rd_at); end
        checks++;
        if ({cap[14], cap[15], cap[16], cap[17], cap[18], cap[19]} !== 24'h5D0010) begin
            errors++; $display("FAIL l64_head: %h%h%h%h%h%h want 5d0010", cap[14], cap[15], cap[16], cap[17], cap[18], cap[19]);
        end
        checks++;
        if (stream_errors(152) !== 0) begin errors++; $display("FAIL l64_stream: %0d bad nibbles want 0", stream_errors(152)); end
        checks++;
        if (done_cnt !== 1 || done_at !== last_txen + 1) begin
            errors++; $display("FAIL l64_done: count=%0d at=%0d want 1 at %0d", done_cnt, done_at, last_txen + 1);
        end
        checks++;
        if (busy_fall !== done_at + 24) begin errors++; $display("FAIL l64_ifg: busy fell %0d want %0d", busy_fall, done_at + 24); end
        checks++;
        if (txd_bad !== 0 || unr_cnt !== 0) begin
            errors++; $display("FAIL l64_idle_txd: txd nonzero %0d times, underruns %0d, want 0 0", txd_bad, unr_cnt);
        end
    endtask

    task automatic test_len1();
        mem[0] = 8'h42;
        build_exp(1);
        kick(1, 1);
        capture(400, 1'b0);
        checks++;
        if (rd_cnt !== 1) begin errors++; $display("FAIL l1_pops: %0d want 1", rd_cnt); end
        checks++;
        if ({cap[16], cap[17], cap[18]} !== 12'h240) begin
            errors++; $display("FAIL l1_payload: %h%h%h want 240", cap[16], cap[17], cap[18]);
        end
        checks++;
        if (cap_n !== 144 || stream_errors(144) !== 0) begin
            errors++; $display("FAIL l1_frame: len=%0d bad=%0d want 144 0", cap_n, stream_errors(144));
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL l1_done: %0d want 1", done_cnt); end
    endtask

    task automatic test_len0();
        build_exp(0);
        kick(0, 0);
        capture(400, 1'b0);
        checks++;
        if (rd_cnt !== 0) begin errors++; $display("FAIL l0_pops: %0d want 0", rd_cnt); end
        checks++;
        if (cap_n !== 144 || stream_errors(144) !== 0) begin
            errors++; $display("FAIL l0_frame: len=%0d bad=%0d want 144 0", cap_n, stream_errors(144));
        end
        checks++;
        if (done_cnt !== 1 || unr_cnt !== 0) begin errors++; $display("FAIL l0_done: done=%0d unr=%0d want 1 0", done_cnt, unr_cnt); end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 2047; i++) mem[i] = 8'((i * 7 + 3) & 255);
        build_exp(2047);
        kick(2047, 2047);
        capture(5000, 1'b0);
        checks++;
        if (rd_cnt !== 2047) begin errors++; $display("FAIL max_pops: %0d want 2047", rd_cnt); end
        checks++;
        if (cap_n !== 4118 || stream_errors(4118) !== 0) begin
            errors++; $display("FAIL max_frame: len=%0d bad=%0d want 4118 0", cap_n, stream_errors(4118));
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL max_done: %0d want 1", done_cnt); end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 100; i++) mem[i] = 8'(i + 128);
        build_exp(100);
        kick(100, 10);
        capture(400, 1'b0);
        checks++;
        if (rd_cnt !== 10) begin errors++; $display("FAIL ur_pops: %0d want 10", rd_cnt); end
        // 16 preamble/SFD nibbles, 9 whole bytes, then the low nibble of byte 9 (the failed slot)
        checks++;
        if (cap_n !== 35 || stream_errors(35) !== 0) begin
            errors++; $display("FAIL ur_txen: len=%0d bad=%0d want 35 0", cap_n, stream_errors(35));
        end
        checks++;
        if (unr_cnt !== 1 || unr_at !== last_txen + 1) begin
            errors++; $display("FAIL ur_pulse: count=%0d at=%0d want 1 at %0d", unr_cnt, unr_at, last_txen + 1);
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL ur_no_done: %0d want 0", done_cnt); end
        checks++;
        if (busy_fall !== unr_at + 24 || txd_bad !== 0) begin
            errors++; $display("FAIL ur_ifg: busy fell %0d want %0d, txd_bad=%0d", busy_fall, unr_at + 24, txd_bad);
        end
    endtask

    task automatic test_back_to_back();
        int n1, l1, bf1, d1;
        build_exp(0);
        kick(0, 0);
        capture(400, 1'b1);
        n1 = cap_n; l1 = last_txen; bf1 = busy_fall; d1 = done_cnt;
        capture(400, 1'b1);
        i_start = 1'b0;
        checks++;
        if (n1 !== 144 || d1 !== 1) begin errors++; $display("FAIL b2b_first: len=%0d done=%0d want 144 1", n1, d1); end
        checks++;
        if (bf1 - l1 !== 25) begin errors++; $display("FAIL b2b_gap: %0d txen-low cycles want 25", bf1 - l1); end
        checks++;
        if (first_txen !== 0) begin errors++; $display("FAIL b2b_restart: second preamble at %0d want 0", first_txen); end
        checks++;
        if (cap_n !== 144 || stream_errors(144) !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL b2b_second: len=%0d bad=%0d done=%0d want 144 0 1", cap_n, stream_errors(144), done_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_mii_txen} !== 2'b00) begin
            errors++; $display("FAIL b2b_stop: busy=%b txen=%b want 0 0", o_busy, o_mii_txen);
        end
    endtask

    task automatic test_reset_mid();
        int  pops;
        int  late_pops;
        logic [3:0] nib20;
        for (int i = 0; i < 100; i++) mem[i] = 8'(i) ^ 8'h5A;
        kick(100, 100);
        pops = 0;
        nib20 = 4'h0;
        for (int c = 0; c <= 56; c++) begin
            @(negedge clk);
            if (c == 0) i_start = 1'b0;
            if (o_fifo_rd === 1'b1) pops++;
            if (c == 56) nib20 = o_mii_txd;
        end
        checks++;
        if (nib20 !== mem[20][3:0] || pops !== 22) begin
            errors++; $display("FAIL rm_before: byte20 nibble=%h pops=%0d want %h 22", nib20, pops, mem[20][3:0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_mii_txen, o_fifo_rd, o_busy, o_done, o_underrun} !== 5'b0) begin
            errors++; $display("FAIL rm_abort: txen=%b rd=%b busy=%b done=%b unr=%b want all 0",
                               o_mii_txen, o_fifo_rd, o_busy, o_done, o_underrun);
        end
        rst = 1'b0;
        late_pops = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_fifo_rd === 1'b1 || o_mii_txen === 1'b1) late_pops++;
        end
        checks++;
        if (late_pops !== 0) begin errors++; $display("FAIL rm_quiet: %0d active cycles want 0", late_pops); end
        for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
        build_exp(5);
        kick(5, 5);
        capture(400, 1'b0);
        checks++;
        if (cap_n !== 144 || stream_errors(144) !== 0 || rd_cnt !== 5 || done_cnt !== 1) begin
            errors++; $display("FAIL rm_recover: len=%0d bad=%0d pops=%0d done=%0d want 144 0 5 1",
                               cap_n, stream_errors(144), rd_cnt, done_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_start    = 1'b0;
        i_len      = '0;
        fifo_clr   = 1'b1;
        fifo_avail = 0;
        i_fifo_data = 8'h00;
        test_crc_model();
        test_reset();
        test_len64();
        test_len1();
        test_len0();
        test_max_len();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
